// File: rtl/wb_queue_if.sv
// Writeback queue bus: ALU result handshake, register-file write port, hazard and forwarding views.
// Forwarding signals exist only when WB_QUEUE_FORWARD_EN is defined.
interface wb_queue_if #(
    parameter int unsigned DATA_W = 13,
    parameter int unsigned ADDR_W = 3
);
    localparam int unsigned NREG = 1 << ADDR_W;

    logic              ResValid;
    logic              ResReady;
    logic [ADDR_W-1:0] ResDest;
    logic [DATA_W-1:0] ResData;
    logic              WbStall;
    logic              WriteFlag;
    logic [ADDR_W-1:0] R1;
    logic [DATA_W-1:0] ALU_Result;
    logic [NREG-1:0]   Pending;
    logic              Empty;
    logic              Full;
`ifdef WB_QUEUE_FORWARD_EN
    logic [ADDR_W-1:0] FwdPtrA;
    logic [ADDR_W-1:0] FwdPtrB;
    logic              FwdHitA;
    logic              FwdHitB;
    logic [DATA_W-1:0] FwdDataA;
    logic [DATA_W-1:0] FwdDataB;

    modport master (
        output ResValid, ResDest, ResData, WbStall, FwdPtrA, FwdPtrB,
        input  ResReady, WriteFlag, R1, ALU_Result, Pending, Empty, Full,
               FwdHitA, FwdHitB, FwdDataA, FwdDataB
    );

    modport slave (
        input  ResValid, ResDest, ResData, WbStall, FwdPtrA, FwdPtrB,
        output ResReady, WriteFlag, R1, ALU_Result, Pending, Empty, Full,
               FwdHitA, FwdHitB, FwdDataA, FwdDataB
    );
`else
    modport master (
        output ResValid, ResDest, ResData, WbStall,
        input  ResReady, WriteFlag, R1, ALU_Result, Pending, Empty, Full
    );

    modport slave (
        input  ResValid, ResDest, ResData, WbStall,
        output ResReady, WriteFlag, R1, ALU_Result, Pending, Empty, Full
    );
`endif
endinterface

// File: rtl/wb_queue.sv
// Result writeback FIFO between the ALU and the register file, with a per-register pending mask.
// Optional newest-entry forwarding for two read pointers under WB_QUEUE_FORWARD_EN.
module wb_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 13,
    parameter int unsigned ADDR_W = 3
) (
    input  logic     Clock,
    input  logic     Reset_n,
    wb_queue_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned NREG  = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic              empty_c;
    logic              full_c;
    logic              push_c;
    logic              pop_c;
    logic [DEPTH-1:0]  live_c;

    // Handshake decisions depend only on registered occupancy plus the stall input.
    always_comb begin
        empty_c = (count_q == '0);
        full_c  = (count_q == CNT_W'(DEPTH));
        push_c  = bus.ResValid && !full_c;
        pop_c   = !empty_c && !bus.WbStall;
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        logic [PTR_W-1:0] offset;
        offset = '0;
        live_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset    = PTR_W'(PTR_W'(i) - rd_ptr_q);
            live_c[i] = (CNT_W'(offset) < count_q);
        end
    end

    always_comb begin
        logic [NREG-1:0] pend;
        pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_c[i]) begin
                pend[mem_q[i].dest] = 1'b1;
            end
        end
        bus.Pending    = pend;
        bus.ResReady   = !full_c;
        bus.Empty      = empty_c;
        bus.Full       = full_c;
        bus.WriteFlag  = pop_c;
        bus.R1         = empty_c ? '0 : mem_q[rd_ptr_q].dest;
        bus.ALU_Result = empty_c ? '0 : mem_q[rd_ptr_q].data;
    end

`ifdef WB_QUEUE_FORWARD_EN
    // Walk oldest to newest so the newest match wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx          = '0;
        bus.FwdHitA  = 1'b0;
        bus.FwdHitB  = 1'b0;
        bus.FwdDataA = '0;
        bus.FwdDataB = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = PTR_W'(rd_ptr_q + PTR_W'(k));
            if (CNT_W'(k) < count_q) begin
                if (mem_q[idx].dest == bus.FwdPtrA) begin
                    bus.FwdHitA  = 1'b1;
                    bus.FwdDataA = mem_q[idx].data;
                end
                if (mem_q[idx].dest == bus.FwdPtrB) begin
                    bus.FwdHitB  = 1'b1;
                    bus.FwdDataB = mem_q[idx].data;
                end
            end
        end
    end
`endif

    // Storage, pointers and occupancy; reset discards anything in flight.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_c) begin
                mem_q[wr_ptr_q] <= entry_t'{dest: bus.ResDest, data: bus.ResData};
                wr_ptr_q        <= PTR_W'(wr_ptr_q + PTR_W'(1));
            end
            if (pop_c) begin
                rd_ptr_q <= PTR_W'(rd_ptr_q + PTR_W'(1));
            end
            case ({push_c, pop_c})
                2'b10:   count_q <= CNT_W'(count_q + CNT_W'(1));
                2'b01:   count_q <= CNT_W'(count_q - CNT_W'(1));
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_queue.sv
// Directed plus randomized bench for wb_queue against a queue-based reference model.
module tb_wb_queue;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DATA_W = 13;
    localparam int unsigned ADDR_W = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] d;
        logic [DATA_W-1:0] v;
    } ent_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;
    ent_t mq[$];

    always #5 clk = ~clk;

    wb_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) q_if ();

    wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .Clock   (clk),
        .Reset_n (rst_n),
        .bus     (q_if.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Compare every output against the model for the currently driven inputs.
    task automatic check_model(input logic st);
        logic [7:0] pend;
        logic       empty;
        pend  = '0;
        empty = (mq.size() == 0);
        foreach (mq[i]) pend[mq[i].d] = 1'b1;
        chk("empty",    32'(q_if.Empty),     32'(empty));
        chk("full",     32'(q_if.Full),      32'(mq.size() == DEPTH));
        chk("ready",    32'(q_if.ResReady),  32'(mq.size() != DEPTH));
        chk("wflag",    32'(q_if.WriteFlag), 32'(!empty && !st));
        chk("r1",       32'(q_if.R1),        empty ? 32'd0 : 32'(mq[0].d));
        chk("alu_res",  32'(q_if.ALU_Result), empty ? 32'd0 : 32'(mq[0].v));
        chk("pending",  32'(q_if.Pending),   32'(pend));
`ifdef WB_QUEUE_FORWARD_EN
        begin
            logic hit_a, hit_b;
            logic [DATA_W-1:0] dat_a, dat_b;
            hit_a = 1'b0; hit_b = 1'b0; dat_a = '0; dat_b = '0;
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (!hit_a && mq[i].d == q_if.FwdPtrA) begin hit_a = 1'b1; dat_a = mq[i].v; end
                if (!hit_b && mq[i].d == q_if.FwdPtrB) begin hit_b = 1'b1; dat_b = mq[i].v; end
            end
            chk("fwd_hit_a",  32'(q_if.FwdHitA),  32'(hit_a));
            chk("fwd_hit_b",  32'(q_if.FwdHitB),  32'(hit_b));
            chk("fwd_data_a", 32'(q_if.FwdDataA), 32'(dat_a));
            chk("fwd_data_b", 32'(q_if.FwdDataB), 32'(dat_b));
        end
`endif
    endtask

    // One clock: drive at the falling edge, check, advance the model at the rising edge.
    task automatic cycle(input logic v, input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] x,
                         input logic st, input logic rn);
        logic wf;
        q_if.ResValid = v;
        q_if.ResDest  = d;
        q_if.ResData  = x;
        q_if.WbStall  = st;
        rst_n         = rn;
        #1;
        check_model(st);
        wf = (mq.size() != 0) && !st;
        if (!rn) begin
            mq.delete();
        end else begin
            logic push;
            push = v && (mq.size() < DEPTH);
            if (wf) void'(mq.pop_front());
            if (push) mq.push_back(ent_t'{d: d, v: x});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        q_if.ResValid = 1'b0;
        q_if.ResDest  = '0;
        q_if.ResData  = '0;
        q_if.WbStall  = 1'b0;
`ifdef WB_QUEUE_FORWARD_EN
        q_if.FwdPtrA  = 3'd5;
        q_if.FwdPtrB  = 3'd6;
`endif
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Reset then idle
        cycle(1'b0, 3'd0, 13'd0, 1'b0, 1'b1);
        chk("rst_empty", 32'(q_if.Empty), 32'd1);
        chk("rst_ready", 32'(q_if.ResReady), 32'd1);
        chk("rst_wflag", 32'(q_if.WriteFlag), 32'd0);
        chk("rst_r1", 32'(q_if.R1), 32'd0);
        chk("rst_alu", 32'(q_if.ALU_Result), 32'd0);
        chk("rst_pend", 32'(q_if.Pending), 32'h00);

        // Single pass-through push
        cycle(1'b1, 3'd3, 13'h1ABC, 1'b0, 1'b1);
        chk("pt_wflag", 32'(q_if.WriteFlag), 32'd1);
        chk("pt_r1", 32'(q_if.R1), 32'd3);
        chk("pt_alu", 32'(q_if.ALU_Result), 32'h1ABC);
        chk("pt_pend", 32'(q_if.Pending), 32'h08);
        cycle(1'b0, 3'd0, 13'd0, 1'b0, 1'b1);
        chk("pt_empty", 32'(q_if.Empty), 32'd1);

        // Fill under stall; fifth push must be refused
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 3'(i), 13'(16'h100 + i), 1'b1, 1'b1);
            if (i == 3) begin
                chk("fill_full", 32'(q_if.Full), 32'd1);
                chk("fill_ready", 32'(q_if.ResReady), 32'd0);
            end
        end
        chk("fill_pend", 32'(q_if.Pending), 32'h0F);
        for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, 13'd0, 1'b0, 1'b1);
        chk("drain_empty", 32'(q_if.Empty), 32'd1);

        // Continuous push and pop across pointer wrap
        for (int i = 0; i < 20; i++)
            cycle(1'b1, 3'($urandom_range(7)), 13'($urandom), 1'b0, 1'b1);
        cycle(1'b0, 3'd0, 13'd0, 1'b0, 1'b1);
        cycle(1'b0, 3'd0, 13'd0, 1'b0, 1'b1);

        // Reset with three entries queued
        for (int i = 0; i < 3; i++) cycle(1'b1, 3'(i + 4), 13'(i + 7), 1'b1, 1'b1);
        cycle(1'b1, 3'd1, 13'h55, 1'b1, 1'b0);
        chk("rq_empty", 32'(q_if.Empty), 32'd1);
        chk("rq_pend", 32'(q_if.Pending), 32'd0);
        cycle(1'b0, 3'd0, 13'd0, 1'b0, 1'b1);

`ifdef WB_QUEUE_FORWARD_EN
        // Newest-match forwarding
        cycle(1'b1, 3'd5, 13'h0011, 1'b1, 1'b1);
        cycle(1'b1, 3'd5, 13'h0022, 1'b1, 1'b1);
        chk("fwd_a_hit", 32'(q_if.FwdHitA), 32'd1);
        chk("fwd_a_data", 32'(q_if.FwdDataA), 32'h0022);
        chk("fwd_b_hit", 32'(q_if.FwdHitB), 32'd0);
        chk("fwd_b_data", 32'(q_if.FwdDataB), 32'd0);
        cycle(1'b0, 3'd0, 13'd0, 1'b1, 1'b0);
`endif

        // Randomized traffic with occasional stalls and resets
        for (int i = 0; i < 400; i++) begin
`ifdef WB_QUEUE_FORWARD_EN
            q_if.FwdPtrA = 3'($urandom_range(7));
            q_if.FwdPtrB = 3'($urandom_range(7));
`endif
            cycle($urandom_range(3) != 0, 3'($urandom_range(7)), 13'($urandom),
                  $urandom_range(3) == 0, $urandom_range(63) != 0);
        end
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 3'd0, 13'd0, 1'b0, 1'b1);
        chk("final_empty", 32'(q_if.Empty), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/wb_queue.md
# wb_queue

Result writeback queue between the ALU and the 8×13-bit register file. It accepts ALU results with a valid/ready handshake and buffers them in a small FIFO. It drives the register file's write port (`R1`, `ALU_Result`, `WriteFlag`) one entry per cycle and holds entries while writeback is stalled. It also exports a per-register pending mask for hazard checks and, optionally, forwards the newest buffered value for two read pointers.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, 2..16
- `DATA_W`, 13, result width
- `ADDR_W`, 3, register pointer width (8 registers)

- `Clock`  in  1  sole clock, rising edge
- `Reset_n`  in  1  synchronous, active-low reset
- `ResValid`  in  1  ALU result valid
- `ResReady`  out  1  queue can accept (`!Full`)
- `ResDest`  in  ADDR_W  destination register
- `ResData`  in  DATA_W  result value
- `WbStall`  in  1  hold writeback; no pop while high
- `WriteFlag`  out  1  register file write enable
- `R1`  out  ADDR_W  register file write pointer
- `ALU_Result`  out  DATA_W  register file write data
- `Pending`  out  8  bit i set when any buffered entry targets register i
- `Empty`  out  1  no entries
- `Full`  out  1  DEPTH entries
- `FwdPtrA`, `FwdPtrB`  in  ADDR_W  forwarding lookup pointers (macro only)
- `FwdHitA`, `FwdHitB`  out  1  lookup matched a buffered entry (macro only)
- `FwdDataA`, `FwdDataB`  out  DATA_W  newest matching data (macro only)

## Operation
- Storage: DEPTH entries of {dest, data}, a write pointer, a read pointer and an occupancy count of width log2(DEPTH)+1. Both pointers wrap modulo DEPTH.
- Push: `ResValid && ResReady` at a rising edge stores {`ResDest`, `ResData`} at the write pointer.
- `ResReady = !Full`. It depends only on registered occupancy; there is no same-cycle pop-through when full.
- Head presentation: `WriteFlag = !Empty && !WbStall`. `R1` and `ALU_Result` show the head entry when `!Empty` and are 0 when `Empty`.
- Pop: `WriteFlag` high at a rising edge advances the read pointer. Each entry is written exactly once, in arrival order.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance. This is legal at any occupancy where the push is accepted, including 0→1→0 pass-through, where a push into an empty queue is written on the following cycle.
- `Pending[i]` is the OR over valid entries of (dest == i). It is combinational from the stored state. Repeated writes to the same register keep the bit set until the last such entry pops.
- All 8 registers, including register 0, are ordinary writable targets.
- Writes to the same register stay in FIFO order, so the last-written value survives.

## Timing
- Reset: when `Reset_n` is low at an edge, occupancy, both pointers and all entries are cleared to 0. `Empty=1`, `Full=0`, `ResReady=1`, `WriteFlag=0`, `R1=0`, `ALU_Result=0`, `Pending=0`, `FwdHit*=0`, `FwdData*=0`.
- Reset takes priority over a push or pop in the same cycle. An in-flight entry is discarded, not written.
- Latency: a result accepted at edge N drives `WriteFlag=1` during cycle N+1, provided the queue was empty and `WbStall=0`.
- Throughput: one push and one pop per cycle.
- Full at DEPTH entries: `ResReady=0`, and `ResValid` is ignored without loss; the producer holds its data.
- `WbStall` is sampled combinationally and gates `WriteFlag` in the same cycle.

## Configuration
- Macro `WB_QUEUE_FORWARD_EN`.
- Defined: for each of `FwdPtrA`/`FwdPtrB`, `FwdHit*` is 1 when any valid entry's dest matches. `FwdData*` is the data of the newest matching entry, nearest the write pointer, and 0 on a miss. The lookup is combinational and excludes the same-cycle `ResData`.
- Undefined: the forwarding ports and their logic are absent.
- Core queue behaviour is identical either way.

## Test plan
- Reset then idle: `Empty=1`, `ResReady=1`, `WriteFlag=0`, `R1=0`, `ALU_Result=0`, `Pending=8'h00`.
- Push {dest 3, 13'h1ABC} with `WbStall=0`: the next cycle shows `WriteFlag=1`, `R1=3`, `ALU_Result=13'h1ABC`, `Pending=8'h08`. The cycle after shows `Empty=1`.
- Hold `WbStall=1` and push five results to dests 0..4: after four pushes `Full=1` and `ResReady=0`, and the fifth is not accepted. `Pending=8'h0F`. Release the stall: writes appear to dests 0,1,2,3 in consecutive cycles.
- Continuous push and pop at DEPTH=4 over 20 results: no entry is dropped, output order matches input order, and pointers wrap correctly.
- `Reset_n` low while 3 entries are queued: the next cycle shows `Empty=1`, `Pending=0`, and no write of the discarded entries.
- With `WB_QUEUE_FORWARD_EN`, stall and push {5, 13'h0011} then {5, 13'h0022}, with `FwdPtrA=5` and `FwdPtrB=6`: `FwdHitA=1`, `FwdDataA=13'h0022`, `FwdHitB=0`, `FwdDataB=0`.
